// File: rtl/operand_stage_pkg.sv
// Shared pipeline definitions: word/tag types, control-bit indices, s3 record.
// No logic of its own; used by the operand stage, the decode stage and the bench.
// No flow control lives here.
package operand_stage_pkg;

  localparam int XLEN    = 32;
  localparam int TAG_W   = 5;
  localparam int INSTR_W = 8;

  typedef logic [XLEN-1:0]    word_t;
  typedef logic [TAG_W-1:0]   tag_t;
  typedef logic [INSTR_W-1:0] instrs_t;

  // Bit positions inside instr_type
  localparam int USE_RS2  = 0;
  localparam int WRITE_RD = 1;
  localparam int DO_LOAD  = 2;

  // Bit positions inside the bypass override vector
  localparam int RS1 = 0;
  localparam int RS2 = 1;

  // One instruction as held in the operand-read stage
  typedef struct packed {
    logic    valid;
    word_t   pc;
    word_t   imm;
    instrs_t instr_type;
    tag_t    rs1;
    tag_t    rs2;
    tag_t    rd;
  } stage3_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable and synchronous clear, for perf monitoring.
// Count visible one cycle after an enabled cycle.
// No backpressure; sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  // Count enabled cycles, holding at the maximum value
  always_ff @(posedge clock) begin
    if (clear) begin
      count <= '0;
    end else if (enable && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/operand_stage.sv
// Operand-read stage (s3) plus its s4a register: RF address steering and bypass merge.
// s2 -> s3 -> s4a, one cycle per hop; each stalled cycle adds one.
// Load-use stall holds s3 and drops s2_ready while a bubble enters s4a; flush overrides stall.
module operand_stage
  import operand_stage_pkg::*;
#(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   s2_valid,
  input  logic [XLEN-1:0]        s2_pc,
  input  logic [INSTR_W-1:0]     s2_instr_type,
  input  logic [TAG_W-1:0]       s2_rs1,
  input  logic [TAG_W-1:0]       s2_rs2,
  input  logic [TAG_W-1:0]       s2_rd,
  input  logic [XLEN-1:0]        s2_imm,
  output logic                   s2_ready,
  output logic [TAG_W-1:0]       rf_rs1_addr,
  output logic [TAG_W-1:0]       rf_rs2_addr,
  input  logic [XLEN-1:0]        rf_rs1_data,
  input  logic [XLEN-1:0]        rf_rs2_data,
  output logic [TAG_W-1:0]       s3_rs1,
  output logic [TAG_W-1:0]       s3_rs2,
  output logic [INSTR_W-1:0]     s3_instr_type,
  input  logic                   stall,
  input  logic [1:0]             bypass,
  input  logic [XLEN-1:0]        rs1_bypass_value,
  input  logic [XLEN-1:0]        rs2_bypass_value,
  input  logic                   flush,
  output logic                   s4a_valid,
  output logic [XLEN-1:0]        s4a_pc,
  output logic [XLEN-1:0]        s4a_imm,
  output logic [INSTR_W-1:0]     s4a_instr_type,
  output logic [TAG_W-1:0]       s4a_rd,
  output logic [XLEN-1:0]        s4a_op1,
  output logic [XLEN-1:0]        s4a_op2,
  output logic [COUNT_WIDTH-1:0] stall_count
);

  stage3_t s2_in;
  stage3_t s3_q;

  assign s2_ready = !stall || flush;

  // While stalled the RF is re-read with the held s3 specifiers so a write
  // retiring during the stall is picked up by the synchronous read.
  assign rf_rs1_addr = s2_ready ? s2_rs1 : s3_q.rs1;
  assign rf_rs2_addr = s2_ready ? s2_rs2 : s3_q.rs2;

  assign s3_rs1        = s3_q.rs1;
  assign s3_rs2        = s3_q.rs2;
  assign s3_instr_type = s3_q.instr_type;

  // Pack the incoming s2 instruction into an s3 record
  always_comb begin
    s2_in            = '0;
    s2_in.valid      = s2_valid;
    s2_in.pc         = s2_pc;
    s2_in.imm        = s2_imm;
    s2_in.instr_type = s2_instr_type;
    s2_in.rs1        = s2_rs1;
    s2_in.rs2        = s2_rs2;
    s2_in.rd         = s2_rd;
  end

  // s3 register: flush kills, stall holds, otherwise advance from s2
  always_ff @(posedge clock) begin
    if (reset) begin
      s3_q <= '0;
    end else if (flush) begin
      s3_q       <= s2_in;
      s3_q.valid <= 1'b0;
    end else if (!stall) begin
      s3_q <= s2_in;
    end
  end

  // s4a register: bubble on stall or flush; operands merge RF data with bypass
  always_ff @(posedge clock) begin
    if (reset) begin
      s4a_valid      <= 1'b0;
      s4a_pc         <= '0;
      s4a_imm        <= '0;
      s4a_instr_type <= '0;
      s4a_rd         <= '0;
      s4a_op1        <= '0;
      s4a_op2        <= '0;
    end else begin
      s4a_valid <= s3_q.valid && !stall && !flush;
      if (!stall) begin
        s4a_pc         <= s3_q.pc;
        s4a_imm        <= s3_q.imm;
        s4a_instr_type <= s3_q.instr_type;
        s4a_rd         <= s3_q.rd;
      end
      // op2 is always captured; the immediate is chosen downstream
      s4a_op1 <= bypass[RS1] ? rs1_bypass_value : rf_rs1_data;
      s4a_op2 <= bypass[RS2] ? rs2_bypass_value : rf_rs2_data;
    end
  end

  // Only stalls that actually hold a live instruction are counted
  sat_counter #(
    .WIDTH (COUNT_WIDTH)
  ) u_stall_counter (
    .clock  (clock),
    .clear  (reset),
    .enable (stall && s3_q.valid && !flush),
    .count  (stall_count)
  );

endmodule

// File: tb/tb_operand_stage.sv
module tb_operand_stage;
  import operand_stage_pkg::*;

  localparam int CW = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          s2_valid;
  logic [31:0]   s2_pc;
  logic [7:0]    s2_instr_type;
  logic [4:0]    s2_rs1, s2_rs2, s2_rd;
  logic [31:0]   s2_imm;
  logic          s2_ready;
  logic [4:0]    rf_rs1_addr, rf_rs2_addr;
  logic [31:0]   rf_rs1_data, rf_rs2_data;
  logic [4:0]    s3_rs1, s3_rs2;
  logic [7:0]    s3_instr_type;
  logic          stall;
  logic [1:0]    bypass;
  logic [31:0]   rs1_bypass_value, rs2_bypass_value;
  logic          flush;
  logic          s4a_valid;
  logic [31:0]   s4a_pc, s4a_imm;
  logic [7:0]    s4a_instr_type;
  logic [4:0]    s4a_rd;
  logic [31:0]   s4a_op1, s4a_op2;
  logic [CW-1:0] stall_count;

  int checks   = 0;
  int failures = 0;

  localparam logic [7:0] T_ALUI = 8'h02;  // write_rd
  localparam logic [7:0] T_ALU  = 8'h03;  // use_rs2 | write_rd

  operand_stage #(.COUNT_WIDTH(CW)) dut (
    .clock            (clock),
    .reset            (reset),
    .s2_valid         (s2_valid),
    .s2_pc            (s2_pc),
    .s2_instr_type    (s2_instr_type),
    .s2_rs1           (s2_rs1),
    .s2_rs2           (s2_rs2),
    .s2_rd            (s2_rd),
    .s2_imm           (s2_imm),
    .s2_ready         (s2_ready),
    .rf_rs1_addr      (rf_rs1_addr),
    .rf_rs2_addr      (rf_rs2_addr),
    .rf_rs1_data      (rf_rs1_data),
    .rf_rs2_data      (rf_rs2_data),
    .s3_rs1           (s3_rs1),
    .s3_rs2           (s3_rs2),
    .s3_instr_type    (s3_instr_type),
    .stall            (stall),
    .bypass           (bypass),
    .rs1_bypass_value (rs1_bypass_value),
    .rs2_bypass_value (rs2_bypass_value),
    .flush            (flush),
    .s4a_valid        (s4a_valid),
    .s4a_pc           (s4a_pc),
    .s4a_imm          (s4a_imm),
    .s4a_instr_type   (s4a_instr_type),
    .s4a_rd           (s4a_rd),
    .s4a_op1          (s4a_op1),
    .s4a_op2          (s4a_op2),
    .stall_count      (stall_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; inputs change and outputs are sampled 1 time unit later
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_s2(input logic v, input logic [31:0] pc, input logic [7:0] ty,
                          input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                          input logic [31:0] imm);
    s2_valid = v; s2_pc = pc; s2_instr_type = ty;
    s2_rs1 = r1; s2_rs2 = r2; s2_rd = rd; s2_imm = imm;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; bypass = 2'b00;
    rs1_bypass_value = '0; rs2_bypass_value = '0;
    rf_rs1_data = '0; rf_rs2_data = '0;
    drive_s2(1'b0, 32'h0, 8'h0, 5'd0, 5'd0, 5'd0, 32'h0);

    // ---- Reset state
    step(); step();
    chk("rst_s4a_valid", {31'b0, s4a_valid}, 32'd0);
    chk("rst_s4a_pc", s4a_pc, 32'd0);
    chk("rst_s3_rs1", {27'b0, s3_rs1}, 32'd0);
    chk("rst_stall_count", {30'b0, stall_count}, 32'd0);
    chk("rst_s2_ready", {31'b0, s2_ready}, 32'd1);
    reset = 1'b0;

    // ---- 1. ALU chain: addi x5,x0,7 ; add x6,x5,x5
    drive_s2(1'b1, 32'h100, T_ALUI, 5'd0, 5'd0, 5'd5, 32'd7);
    #1 chk("t1_rf_rs1_addr_from_s2", {27'b0, rf_rs1_addr}, 32'd0);
    step();
    chk("t1_s3_rd_type", {24'b0, s3_instr_type}, {24'b0, T_ALUI});
    drive_s2(1'b1, 32'h104, T_ALU, 5'd5, 5'd5, 5'd6, 32'd0);
    step();
    chk("t1_addi_s4a_valid", {31'b0, s4a_valid}, 32'd1);
    chk("t1_addi_s4a_pc", s4a_pc, 32'h100);
    chk("t1_addi_s4a_imm", s4a_imm, 32'd7);
    chk("t1_addi_s4a_rd", {27'b0, s4a_rd}, 32'd5);
    chk("t1_addi_s4a_op1_x0", s4a_op1, 32'd0);
    chk("t1_add_s3_rs1", {27'b0, s3_rs1}, 32'd5);
    chk("t1_add_s3_rs2", {27'b0, s3_rs2}, 32'd5);
    bypass = 2'b11; rs1_bypass_value = 32'd7; rs2_bypass_value = 32'd7;
    drive_s2(1'b0, 32'h0, 8'h0, 5'd0, 5'd0, 5'd0, 32'h0);
    step();
    chk("t1_add_s4a_valid", {31'b0, s4a_valid}, 32'd1);
    chk("t1_add_s4a_op1", s4a_op1, 32'd7);
    chk("t1_add_s4a_op2", s4a_op2, 32'd7);
    chk("t1_add_s4a_rd", {27'b0, s4a_rd}, 32'd6);
    chk("t1_add_s4a_type", {24'b0, s4a_instr_type}, {24'b0, T_ALU});
    bypass = 2'b00;

    // ---- 2. Load-use stall for one cycle on x5
    drive_s2(1'b1, 32'h108, T_ALU, 5'd5, 5'd2, 5'd7, 32'h0);
    step();
    drive_s2(1'b1, 32'h10C, T_ALU, 5'd1, 5'd2, 5'd8, 32'h0);
    stall = 1'b1;
    #1;
    chk("t2_s2_ready_stalled", {31'b0, s2_ready}, 32'd0);
    chk("t2_rf_rs1_addr_held", {27'b0, rf_rs1_addr}, 32'd5);
    step();
    chk("t2_s3_rs1_held", {27'b0, s3_rs1}, 32'd5);
    chk("t2_bubble", {31'b0, s4a_valid}, 32'd0);
    chk("t2_stall_count", {30'b0, stall_count}, 32'd1);
    stall = 1'b0; bypass = 2'b01; rs1_bypass_value = 32'hDEADBEEF; rf_rs2_data = 32'h22;
    #1 chk("t2_rf_rs1_addr_next", {27'b0, rf_rs1_addr}, 32'd1);
    step();
    chk("t2_s4a_valid", {31'b0, s4a_valid}, 32'd1);
    chk("t2_s4a_pc", s4a_pc, 32'h108);
    chk("t2_s4a_op1_bypass", s4a_op1, 32'hDEADBEEF);
    chk("t2_s4a_op2_rf", s4a_op2, 32'h22);
    chk("t2_s3_rs1_advanced", {27'b0, s3_rs1}, 32'd1);
    chk("t2_count_no_inc", {30'b0, stall_count}, 32'd1);
    bypass = 2'b00;

    // ---- 3. Two-cycle stall while the RF retires a write to x2
    drive_s2(1'b1, 32'h110, T_ALU, 5'd3, 5'd4, 5'd9, 32'h0);
    stall = 1'b1; rf_rs2_data = 32'd3;
    #1 chk("t3_rf_rs2_addr_held", {27'b0, rf_rs2_addr}, 32'd2);
    step();
    rf_rs2_data = 32'd9;
    step();
    chk("t3_stall_count", {30'b0, stall_count}, 32'd3);
    stall = 1'b0; rf_rs1_data = 32'h11;
    step();
    chk("t3_s4a_valid", {31'b0, s4a_valid}, 32'd1);
    chk("t3_s4a_pc", s4a_pc, 32'h10C);
    chk("t3_s4a_op2_retired", s4a_op2, 32'd9);
    chk("t3_s4a_op1", s4a_op1, 32'h11);

    // ---- 5. Reset with s3 and s4a both valid
    reset = 1'b1;
    drive_s2(1'b1, 32'h500, T_ALU, 5'd7, 5'd8, 5'd9, 32'h44);
    step();
    reset = 1'b0;
    drive_s2(1'b0, 32'h0, 8'h0, 5'd0, 5'd0, 5'd0, 32'h0);
    rf_rs1_data = '0; rf_rs2_data = '0;
    #1;
    chk("t5_s4a_valid", {31'b0, s4a_valid}, 32'd0);
    chk("t5_s4a_pc", s4a_pc, 32'd0);
    chk("t5_s4a_op1", s4a_op1, 32'd0);
    chk("t5_s4a_op2", s4a_op2, 32'd0);
    chk("t5_s4a_rd", {27'b0, s4a_rd}, 32'd0);
    chk("t5_s3_rs1", {27'b0, s3_rs1}, 32'd0);
    chk("t5_s3_type", {24'b0, s3_instr_type}, 32'd0);
    chk("t5_stall_count", {30'b0, stall_count}, 32'd0);
    step();
    chk("t5_s3_invalid_after_reset", {31'b0, s4a_valid}, 32'd0);
    drive_s2(1'b1, 32'h200, T_ALUI, 5'd1, 5'd2, 5'd3, 32'd5);
    step();
    drive_s2(1'b0, 32'h0, 8'h0, 5'd0, 5'd0, 5'd0, 32'h0);
    rf_rs1_data = 32'h55; rf_rs2_data = 32'h66;
    step();
    chk("t5_refill_valid", {31'b0, s4a_valid}, 32'd1);
    chk("t5_refill_pc", s4a_pc, 32'h200);
    chk("t5_refill_imm", s4a_imm, 32'd5);
    chk("t5_refill_op1", s4a_op1, 32'h55);

    // ---- 4. Flush and stall in the same cycle
    drive_s2(1'b1, 32'h300, T_ALU, 5'd4, 5'd5, 5'd6, 32'h0);
    step();
    drive_s2(1'b1, 32'h304, T_ALU, 5'd6, 5'd7, 5'd8, 32'h0);
    stall = 1'b1; flush = 1'b1;
    #1;
    chk("t4_s2_ready", {31'b0, s2_ready}, 32'd1);
    chk("t4_rf_rs1_addr_from_s2", {27'b0, rf_rs1_addr}, 32'd6);
    step();
    chk("t4_s4a_valid", {31'b0, s4a_valid}, 32'd0);
    chk("t4_stall_count", {30'b0, stall_count}, 32'd0);
    stall = 1'b0; flush = 1'b0;
    drive_s2(1'b0, 32'h0, 8'h0, 5'd0, 5'd0, 5'd0, 32'h0);
    step();
    chk("t4_s3_was_killed", {31'b0, s4a_valid}, 32'd0);

    // ---- 6. Saturation with a 2-bit counter
    drive_s2(1'b1, 32'h400, T_ALU, 5'd1, 5'd1, 5'd2, 32'h0);
    step();
    stall = 1'b1;
    step(); chk("t6_count_1", {30'b0, stall_count}, 32'd1);
    step(); chk("t6_count_2", {30'b0, stall_count}, 32'd2);
    step(); chk("t6_count_3", {30'b0, stall_count}, 32'd3);
    step(); chk("t6_count_sat_a", {30'b0, stall_count}, 32'd3);
    step(); chk("t6_count_sat_b", {30'b0, stall_count}, 32'd3);
    step(); chk("t6_count_sat_c", {30'b0, stall_count}, 32'd3);
    chk("t6_bubble", {31'b0, s4a_valid}, 32'd0);
    stall = 1'b0;
    step();
    chk("t6_release_valid", {31'b0, s4a_valid}, 32'd1);
    chk("t6_release_pc", s4a_pc, 32'h400);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
